// File: rtl/fdiv_period_monitor_pkg.sv
// Shared definitions for the clock-divider family: monitor FSM encoding and
// status counter width.
package fdiv_period_monitor_pkg;

    localparam logic [2:0] ST_IDLE = 3'b001;
    localparam logic [2:0] ST_MEAS = 3'b010;
    localparam logic [2:0] ST_LOCK = 3'b100;

    localparam int ERR_CW = 8;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_MEAS = ST_MEAS,
        S_LOCK = ST_LOCK
    } mon_state_t;

endpackage

// File: rtl/fdiv_period_monitor_rise_det.sv
// Single-flop rising-edge detector for a clk-synchronous pulse train.
module rise_det (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q_d,
    output logic rise
);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) q_d <= 1'b0;
        else        q_d <= d;
    end

    assign rise = d & ~q_d;

endmodule

// File: rtl/fdiv_period_monitor.sv
// Period checker for a divided pulse train: measures clk cycles between rising
// edges, tracks lock against DIV, and reports mismatches and stuck inputs.
module fdiv_period_monitor
    import fdiv_period_monitor_pkg::*;
#(
    parameter int DIV    = 3,
    parameter int CW     = 4,
    parameter int LOCK_N = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              clr,
    input  logic              pulse_in,
    output logic [CW-1:0]     period,
    output logic              period_vld,
    output logic              locked,
    output logic              err,
    output logic [ERR_CW-1:0] err_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    mon_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    good, good_nx;
    logic          pin_q, rise;
    logic          meas, bad;

    // Edge detector keeps tracking pulse_in through clr so the first edge
    // after a clear is judged against the true previous sample.
    rise_det u_rise_det (
        .clk   (clk),
        .rst_b (rst_b),
        .d     (pulse_in),
        .q_d   (pin_q),
        .rise  (rise)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)   state <= S_IDLE;
        else if (clr) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        good_nx  = good;
        meas     = 1'b0;
        bad      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nx = S_MEAS;
                    cnt_nx   = CW'(1);
                end
            end
            S_MEAS, S_LOCK: begin
                if (rise) begin
                    // A rise wins over saturation: it is a (bad) period, not a timeout.
                    meas   = 1'b1;
                    cnt_nx = CW'(1);
                    if (cnt == CW'(DIV)) begin
                        good_nx = (good == 4'(LOCK_N)) ? good : good + 4'd1;
                        if (good_nx == 4'(LOCK_N)) state_nx = S_LOCK;
                    end else begin
                        bad      = 1'b1;
                        good_nx  = '0;
                        state_nx = S_MEAS;
                    end
                end else if (cnt == CNT_MAX) begin
                    bad      = 1'b1;
                    good_nx  = '0;
                    cnt_nx   = '0;
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt        <= '0;
            good       <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else if (clr) begin
            cnt        <= '0;
            good       <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            cnt        <= cnt_nx;
            good       <= good_nx;
            period_vld <= meas;
            locked     <= (state_nx == S_LOCK);
            err        <= bad;
            if (meas) period <= cnt;
            if (bad && err_cnt != '1) err_cnt <= err_cnt + ERR_CW'(1);
        end
    end

endmodule
